// File: rtl/rv_pkg.sv
// Shared decode definitions: opcodes, format encoding, funct codes and the
// decoded control bundle carried through the decode stage registers.
package rv_pkg;

   // Base opcodes, inst[6:0]
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Instruction formats as seen on out_fmt
   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   // Load widths
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store widths
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Branch conditions
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // ALU funct codes that gate the funct7 legality rules
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SRX  = 3'b101;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Everything in the decoded bundle except the XLEN-wide immediate and PC
   typedef struct packed {
      logic [6:0] op;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [6:0] funct7;
      fmt_e       fmt;
      logic       rs1_en;
      logic       rs2_en;
      logic       rd_we;
      logic       illegal;
   } dec_ctrl_t;

   function automatic logic is_load_f3(input logic [2:0] f3);
      return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
   endfunction

   function automatic logic is_store_f3(input logic [2:0] f3);
      return f3 inside {F3_SB, F3_SH, F3_SW};
   endfunction

   function automatic logic is_branch_f3(input logic [2:0] f3);
      return f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
   endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I decode: instruction word to control bundle,
// sign-extended immediate and illegal flag. Illegal words decode as a NOP.
module rv_decode_comb
   import rv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic [31:0]     inst,
   output dec_ctrl_t       ctrl,
   output logic [XLEN-1:0] imm
);

   localparam logic [5:0] NREG_LIM = 6'(NREG);

   logic [6:0] op;
   logic [6:0] f7;
   logic [2:0] f3;
   logic [4:0] rs1_f;
   logic [4:0] rs2_f;
   logic [4:0] rd_f;

   assign op    = inst[6:0];
   assign f7    = inst[31:25];
   assign f3    = inst[14:12];
   assign rs1_f = inst[19:15];
   assign rs2_f = inst[24:20];
   assign rd_f  = inst[11:7];

   fmt_e               fmt;
   logic               known;
   logic               fn_bad;
   logic               shift_imm;
   logic               use_rs1;
   logic               use_rs2;
   logic               use_rd;
   logic               reg_bad;
   logic               illegal;
   logic signed [31:0] imm32;
   logic [XLEN-1:0]    imm_x;

   // Opcode to format, with the per-opcode funct legality rules
   always_comb begin
      known     = 1'b1;
      fn_bad    = 1'b0;
      fmt       = FMT_R;
      shift_imm = 1'b0;
      case (op)
         OP_LOAD: begin
            fmt    = FMT_I;
            fn_bad = !is_load_f3(f3);
         end
         OP_IMM: begin
            fmt       = FMT_I;
            shift_imm = (f3 == F3_SLL) || (f3 == F3_SRX);
            if (f3 == F3_SLL)
               fn_bad = (f7 != F7_BASE);
            else if (f3 == F3_SRX)
               fn_bad = (f7 != F7_BASE) && (f7 != F7_ALT);
         end
         OP_AUIPC, OP_LUI: fmt = FMT_U;
         OP_STORE: begin
            fmt    = FMT_S;
            fn_bad = !is_store_f3(f3);
         end
         OP_OP: begin
            fmt    = FMT_R;
            fn_bad = !((f7 == F7_BASE) ||
                       ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRX))));
         end
         OP_BRANCH: begin
            fmt    = FMT_B;
            fn_bad = !is_branch_f3(f3);
         end
         OP_JALR: begin
            fmt    = FMT_I;
            fn_bad = (f3 != 3'b000);
         end
         OP_JAL: fmt = FMT_J;
         default: known = 1'b0;
      endcase
      // Compressed / reserved length encodings are not handled here
      if (inst[1:0] != 2'b11)
         known = 1'b0;
   end

   // Immediate assembly per format, 32-bit signed before widening
   always_comb begin
      case (fmt)
         FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
         FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U:   imm32 = {inst[31:12], 12'h000};
         FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // Signed cast carries inst[31] up to XLEN
   assign imm_x = XLEN'(imm32);

   assign use_rs1 = !(fmt inside {FMT_U, FMT_J});
   assign use_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
   assign use_rd  = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};

   // Only register fields the format actually uses can make the word illegal
   assign reg_bad = (use_rs1 && ({1'b0, rs1_f} >= NREG_LIM)) ||
                    (use_rs2 && ({1'b0, rs2_f} >= NREG_LIM)) ||
                    (use_rd  && ({1'b0, rd_f}  >= NREG_LIM));

   assign illegal = !known || fn_bad || reg_bad;

   assign imm = illegal ? '0 : imm_x;

   // Bundle assembly; unused fields stay zero and illegal words become NOPs
   always_comb begin
      ctrl         = '0;
      ctrl.op      = op;
      ctrl.illegal = illegal;
      if (!illegal) begin
         ctrl.fmt    = fmt;
         ctrl.rs1    = use_rs1 ? rs1_f : 5'd0;
         ctrl.rs2    = use_rs2 ? rs2_f : 5'd0;
         ctrl.rd     = use_rd  ? rd_f  : 5'd0;
         // U/J are exactly the formats without rs1, and they carry no funct3
         ctrl.funct3 = use_rs1 ? f3 : 3'd0;
         ctrl.funct7 = ((fmt == FMT_R) || shift_imm) ? f7 : 7'd0;
         ctrl.rs1_en = use_rs1;
         ctrl.rs2_en = use_rs2;
         ctrl.rd_we  = use_rd && (rd_f != 5'd0);
      end
   end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage between fetch and register read. One main output
// register plus an optional skid entry so in_ready can be a pure flop.
module rv_decode_stage
   import rv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int SKID = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_op,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_rs1_en,
   output logic            out_rs2_en,
   output logic            out_rd_we,
   output logic            out_illegal
);

   dec_ctrl_t       dec_ctrl;
   logic [XLEN-1:0] dec_imm;

   rv_decode_comb #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_dec (
      .inst (in_inst),
      .ctrl (dec_ctrl),
      .imm  (dec_imm)
   );

   logic            main_vld;
   dec_ctrl_t       main_ctrl;
   logic [XLEN-1:0] main_imm;
   logic [XLEN-1:0] main_pc;

   logic            skid_vld;
   dec_ctrl_t       skid_ctrl;
   logic [XLEN-1:0] skid_imm;
   logic [XLEN-1:0] skid_pc;

   logic            main_free;
   logic            accept;

   // Main can take a new word when empty or when its current word leaves
   assign main_free = !main_vld || out_ready;
   // A word handshaked during flush is discarded
   assign accept    = in_valid && in_ready && !flush;

   // Main register: skid has priority so order is preserved
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld  <= 1'b0;
         main_ctrl <= '0;
         main_imm  <= '0;
         main_pc   <= '0;
      end else if (flush) begin
         main_vld <= 1'b0;
      end else if (main_free) begin
         if (skid_vld) begin
            main_vld  <= 1'b1;
            main_ctrl <= skid_ctrl;
            main_imm  <= skid_imm;
            main_pc   <= skid_pc;
         end else if (accept) begin
            main_vld  <= 1'b1;
            main_ctrl <= dec_ctrl;
            main_imm  <= dec_imm;
            main_pc   <= in_pc;
         end else begin
            main_vld <= 1'b0;
         end
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         // Skid entry: catches the word accepted while main is stalled
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               skid_vld  <= 1'b0;
               skid_ctrl <= '0;
               skid_imm  <= '0;
               skid_pc   <= '0;
            end else if (flush) begin
               skid_vld <= 1'b0;
            end else if (skid_vld) begin
               if (main_free)
                  skid_vld <= 1'b0;
            end else if (accept && !main_free) begin
               skid_vld  <= 1'b1;
               skid_ctrl <= dec_ctrl;
               skid_imm  <= dec_imm;
               skid_pc   <= in_pc;
            end
         end

         // Registered ready: any word accepted always has a place to land
         assign in_ready = !skid_vld;
      end else begin : g_noskid
         assign skid_vld  = 1'b0;
         assign skid_ctrl = '0;
         assign skid_imm  = '0;
         assign skid_pc   = '0;
         assign in_ready  = main_free;
      end
   endgenerate

   assign out_valid   = main_vld;
   assign out_pc      = main_pc;
   assign out_imm     = main_imm;
   assign out_op      = main_ctrl.op;
   assign out_rs1     = main_ctrl.rs1;
   assign out_rs2     = main_ctrl.rs2;
   assign out_rd      = main_ctrl.rd;
   assign out_funct3  = main_ctrl.funct3;
   assign out_funct7  = main_ctrl.funct7;
   assign out_fmt     = main_ctrl.fmt;
   assign out_rs1_en  = main_ctrl.rs1_en;
   assign out_rs2_en  = main_ctrl.rs2_en;
   assign out_rd_we   = main_ctrl.rd_we;
   assign out_illegal = main_ctrl.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed vector table, handshake / flush / reset
// sequences, then randomized traffic against a reference decode model.
module tb_rv_decode_stage;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [2:0]  fmt;
      logic [6:0]  f7;
      logic [63:0] imm;
      logic        rs1_en;
      logic        rs2_en;
      logic        rd_we;
      logic        illegal;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      exp_t        e;
   } vec_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_inst = '0;
   logic [31:0] in_pc = '0;
   logic [63:0] in_pc64;

   assign in_pc64 = {32'h0, in_pc};

   always #5 clk = ~clk;

   // a_: XLEN=32 NREG=32 SKID=1, b_: XLEN=64, c_: NREG=16 SKID=0
   logic        a_rdy, a_vld, a_r1e, a_r2e, a_we, a_ill;
   logic [31:0] a_pc, a_imm;
   logic [6:0]  a_op, a_f7;
   logic [4:0]  a_rs1, a_rs2, a_rd;
   logic [2:0]  a_f3, a_fmt;
   logic        b_rdy, b_vld, b_r1e, b_r2e, b_we, b_ill;
   logic [63:0] b_pc, b_imm;
   logic [6:0]  b_op, b_f7;
   logic [4:0]  b_rs1, b_rs2, b_rd;
   logic [2:0]  b_f3, b_fmt;
   logic        c_rdy, c_vld, c_r1e, c_r2e, c_we, c_ill;
   logic [31:0] c_pc, c_imm;
   logic [6:0]  c_op, c_f7;
   logic [4:0]  c_rs1, c_rs2, c_rd;
   logic [2:0]  c_f3, c_fmt;

   rv_decode_stage #(.XLEN(32), .NREG(32), .SKID(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_vld), .out_ready(out_ready),
      .out_pc(a_pc), .out_op(a_op), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
      .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm), .out_fmt(a_fmt),
      .out_rs1_en(a_r1e), .out_rs2_en(a_r2e), .out_rd_we(a_we), .out_illegal(a_ill));

   rv_decode_stage #(.XLEN(64), .NREG(32), .SKID(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
      .in_inst(in_inst), .in_pc(in_pc64), .out_valid(b_vld), .out_ready(out_ready),
      .out_pc(b_pc), .out_op(b_op), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
      .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm), .out_fmt(b_fmt),
      .out_rs1_en(b_r1e), .out_rs2_en(b_r2e), .out_rd_we(b_we), .out_illegal(b_ill));

   rv_decode_stage #(.XLEN(32), .NREG(16), .SKID(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_rdy),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(c_vld), .out_ready(out_ready),
      .out_pc(c_pc), .out_op(c_op), .out_rs1(c_rs1), .out_rs2(c_rs2), .out_rd(c_rd),
      .out_funct3(c_f3), .out_funct7(c_f7), .out_imm(c_imm), .out_fmt(c_fmt),
      .out_rs1_en(c_r1e), .out_rs2_en(c_r2e), .out_rd_we(c_we), .out_illegal(c_ill));

   exp_t a_got, b_got, c_got;
   assign a_got = {a_rs1, a_rs2, a_rd, a_f3, a_fmt, a_f7, {{32{a_imm[31]}}, a_imm},
                   a_r1e, a_r2e, a_we, a_ill};
   assign b_got = {b_rs1, b_rs2, b_rd, b_f3, b_fmt, b_f7, b_imm, b_r1e, b_r2e, b_we, b_ill};
   assign c_got = {c_rs1, c_rs2, c_rd, c_f3, c_fmt, c_f7, {{32{c_imm[31]}}, c_imm},
                   c_r1e, c_r2e, c_we, c_ill};

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input int r1, input int r2, input int rd, input int f3,
                               input int fmt, input int f7, input logic [63:0] imm,
                               input bit e1, input bit e2, input bit we, input bit ill);
      exp_t e;
      e.rs1 = 5'(r1); e.rs2 = 5'(r2); e.rd = 5'(rd); e.f3 = 3'(f3);
      e.fmt = 3'(fmt); e.f7 = 7'(f7); e.imm = imm;
      e.rs1_en = e1; e.rs2_en = e2; e.rd_we = we; e.illegal = ill;
      return e;
   endfunction

   // Reference decode straight from the ISA rules; immediate is sign-extended to 64
   function automatic exp_t model(input logic [31:0] i, input int nreg);
      exp_t   e;
      int     fmt, f3, f7, op;
      bit     ok, u1, u2, ud, bad;
      longint sx, imm;
      e   = '0;
      fmt = -1;
      ok  = 1'b1;
      f3  = int'(i[14:12]);
      f7  = int'(i[31:25]);
      op  = int'(i[6:0]);
      sx  = longint'($signed(i));
      if (i[1:0] == 2'b11) begin
         case (op)
            'h03: begin fmt = 1; ok = f3 inside {0, 1, 2, 4, 5}; end
            'h13: begin fmt = 1; ok = !((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32)); end
            'h17, 'h37: fmt = 4;
            'h23: begin fmt = 2; ok = (f3 < 3); end
            'h33: begin fmt = 0; ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)); end
            'h63: begin fmt = 3; ok = !(f3 == 2 || f3 == 3); end
            'h67: begin fmt = 1; ok = (f3 == 0); end
            'h6f: fmt = 5;
            default: fmt = -1;
         endcase
      end
      case (fmt)
         1: imm = sx >>> 20;
         2: imm = (sx >>> 25) * 32 + longint'(i[11:7]);
         3: imm = (sx >>> 31) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                  + longint'(i[11:8]) * 2;
         4: imm = (sx >>> 12) * 4096;
         5: imm = (sx >>> 31) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                  + longint'(i[30:21]) * 2;
         default: imm = 0;
      endcase
      u1  = fmt inside {0, 1, 2, 3};
      u2  = fmt inside {0, 2, 3};
      ud  = fmt inside {0, 1, 4, 5};
      bad = (u1 && int'(i[19:15]) >= nreg) || (u2 && int'(i[24:20]) >= nreg) ||
            (ud && int'(i[11:7]) >= nreg);
      if (fmt < 0 || !ok || bad) begin
         e.illegal = 1'b1;
         return e;
      end
      e.fmt    = 3'(fmt);
      e.imm    = imm;
      e.rs1    = u1 ? i[19:15] : 5'd0;
      e.rs2    = u2 ? i[24:20] : 5'd0;
      e.rd     = ud ? i[11:7] : 5'd0;
      e.f3     = u1 ? i[14:12] : 3'd0;
      e.f7     = (fmt == 0 || (op == 'h13 && (f3 == 1 || f3 == 5))) ? i[31:25] : 7'd0;
      e.rs1_en = u1;
      e.rs2_en = u2;
      e.rd_we  = ud && (i[11:7] != 5'd0);
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6f};
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 15) != 0)
         r[6:0] = ops[$urandom_range(0, 8)];
      if (r[6:0] == 7'h33 && $urandom_range(0, 1) == 1)
         r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return r;
   endfunction

   // One word in, sampled one cycle later with out_ready high
   task automatic send(input logic [31:0] inst, input logic [31:0] pc);
      @(posedge clk); #1;
      in_valid = 1'b1; in_inst = inst; in_pc = pc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   vec_t  tbl [10];
   pend_t q [$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0].inst = 32'hFFF10093; tbl[0].e = mk(2, 0, 1, 0, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0, 1, 0);
      tbl[1].inst = 32'h0051A423; tbl[1].e = mk(3, 5, 0, 2, 2, 0, 64'h8, 1, 1, 0, 0);
      tbl[2].inst = 32'hFE000EE3; tbl[2].e = mk(0, 0, 0, 0, 3, 0, 64'hFFFFFFFFFFFFFFFC, 1, 1, 0, 0);
      tbl[3].inst = 32'h123453B7; tbl[3].e = mk(0, 0, 7, 0, 4, 0, 64'h12345000, 0, 0, 1, 0);
      tbl[4].inst = 32'h00000000; tbl[4].e = mk(0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 1);
      tbl[5].inst = 32'h000090E7; tbl[5].e = mk(0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 1);
      tbl[6].inst = 32'h002088B3; tbl[6].e = mk(1, 2, 17, 0, 0, 0, 64'h0, 1, 1, 1, 0);
      tbl[7].inst = 32'h40525193; tbl[7].e = mk(4, 0, 3, 5, 1, 'h20, 64'h405, 1, 0, 1, 0);
      tbl[8].inst = 32'hFF9FF06F; tbl[8].e = mk(0, 0, 0, 0, 5, 0, 64'hFFFFFFFFFFFFFFF8, 0, 0, 0, 0);
      tbl[9].inst = 32'h402090B3; tbl[9].e = mk(0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 1);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("reset out_valid", a_vld, 1'b0);
      chk("reset in_ready", a_rdy, 1'b1);
      chk("reset out_pc", a_pc, 32'h0);
      chk("reset bundle", a_got, '0);

      // Directed vectors, one cycle latency
      for (int i = 0; i < 10; i++) begin
         logic [31:0] pc;
         pc = 32'h1000 + 32'(i * 4);
         send(tbl[i].inst, pc);
         chk($sformatf("vec%0d out_valid", i), a_vld, 1'b1);
         chk($sformatf("vec%0d bundle", i), a_got, tbl[i].e);
         chk($sformatf("vec%0d out_pc", i), a_pc, pc);
         chk($sformatf("vec%0d out_op", i), a_op, tbl[i].inst[6:0]);
         chk($sformatf("vec%0d xlen64 bundle", i), b_got, model(tbl[i].inst, 32));
         chk($sformatf("vec%0d nreg16 bundle", i), c_got, model(tbl[i].inst, 16));
         if (i == 3) chk("lui imm xlen64", b_imm, 64'h0000000012345000);
         if (i == 6) begin
            chk("add x17 nreg16 illegal", c_ill, 1'b1);
            chk("add x17 nreg16 enables", {c_r1e, c_r2e, c_we, c_rd}, '0);
         end
      end

      // Backpressure: two words held, third stalls, then drained in order
      step(); out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF10093; in_pc = 32'h100;
      @(negedge clk); chk("bp A in_ready", a_rdy, 1'b1);
      step(); in_inst = 32'h0051A423; in_pc = 32'h104;
      @(negedge clk); chk("bp B in_ready", a_rdy, 1'b1); chk("bp A out_pc", a_pc, 32'h100);
      step(); in_inst = 32'h123453B7; in_pc = 32'h108;
      @(negedge clk); chk("bp skid full in_ready", a_rdy, 1'b0); chk("bp A hold", a_pc, 32'h100);
      step();
      @(negedge clk); chk("bp still stalled", a_rdy, 1'b0); chk("bp A hold2", a_pc, 32'h100);
      step(); out_ready = 1'b1;
      @(negedge clk); chk("bp emit A valid", a_vld, 1'b1); chk("bp emit A pc", a_pc, 32'h100);
      step();
      @(negedge clk); chk("bp emit B pc", a_pc, 32'h104); chk("bp emit B rs2", a_rs2, 5'd5);
      chk("bp ready after drain", a_rdy, 1'b1);
      step(); in_valid = 1'b0;
      @(negedge clk); chk("bp emit C pc", a_pc, 32'h108); chk("bp emit C rd", a_rd, 5'd7);
      chk("bp emit C valid", a_vld, 1'b1);
      step();
      @(negedge clk); chk("bp empty after C", a_vld, 1'b0);

      // Flush with both entries full and a word offered
      step(); out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF10093; in_pc = 32'h200;
      step(); in_pc = 32'h204;
      step(); in_pc = 32'h208; flush = 1'b1;
      @(negedge clk); chk("flush pre main full", a_vld, 1'b1); chk("flush pre skid full", a_rdy, 1'b0);
      step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk); chk("flush out_valid", a_vld, 1'b0); chk("flush in_ready", a_rdy, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge clk); chk($sformatf("flush no emit %0d", k), a_vld, 1'b0);
      end
      // A word handshaked in the flush cycle is dropped
      step(); in_valid = 1'b1; in_inst = 32'h0051A423; in_pc = 32'h300; flush = 1'b1;
      @(negedge clk); chk("flush-cycle in_ready", a_rdy, 1'b1);
      step(); in_valid = 1'b0; flush = 1'b0;
      @(negedge clk); chk("flush-cycle word dropped", a_vld, 1'b0);

      // Asynchronous reset mid-stream
      step(); out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF10093; in_pc = 32'h400;
      step(); in_valid = 1'b0;
      @(negedge clk); chk("rst pre valid", a_vld, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst async out_valid", a_vld, 1'b0);
      chk("rst async out_pc", a_pc, 32'h0);
      chk("rst async bundle", a_got, '0);
      chk("rst async in_ready", a_rdy, 1'b1);
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk); chk("rst release in_ready", a_rdy, 1'b1); chk("rst release valid", a_vld, 1'b0);

      // Random traffic with random backpressure against the reference model
      for (int cyc = 0; cyc < 600; cyc++) begin
         step();
         in_valid  = ($urandom_range(0, 9) < 7);
         in_inst   = rand_inst();
         in_pc     = $urandom;
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (a_vld && out_ready) begin
            if (q.size() == 0) begin
               chk("rand unexpected output", a_vld, 1'b0);
            end else begin
               pend_t p;
               p = q.pop_front();
               chk($sformatf("rand %0d bundle inst=%h", cyc, p.inst), a_got, model(p.inst, 32));
               chk($sformatf("rand %0d pc", cyc), a_pc, p.pc);
               chk($sformatf("rand %0d xlen64 bundle", cyc), b_got, model(p.inst, 32));
            end
         end
         if (in_valid && a_rdy) q.push_back('{in_inst, in_pc});
      end
      step(); in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 6 && q.size() > 0; k++) begin
         @(negedge clk);
         if (a_vld) begin
            pend_t p;
            p = q.pop_front();
            chk("drain bundle", a_got, model(p.inst, 32));
            chk("drain pc", a_pc, p.pc);
         end
         step();
      end
      chk("scoreboard empty", 32'(q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
